// File: rtl/trap_handler_unit.sv
// trap_handler_unit: supervisor trap sequencer that drains the pipeline, redirects fetch to stvec and returns to sepc on SRET
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   exception_flag_i  trap request from the exception detector
//   scause_i          cause code, valid with exception_flag_i
//   sepc_i            faulting PC, valid with exception_flag_i
//   sret_i            SRET decoded in ID, one-cycle pulse
//   csr_we_i          CSR write strobe
//   csr_addr_i        CSR address: 0x105 stvec, 0x141 sepc, 0x142 scause
//   csr_wdata_i       CSR write data
//   csr_rdata_o       combinational CSR read data, unknown addresses read 0
//   flush_o           squash IF/ID/EX
//   stall_if_o        freeze the PC register
//   pc_redirect_o     one-cycle strobe to load pc_target_o into PC
//   pc_target_o       redirect address
//   in_trap_o         trap handler is executing
//   double_fault_o    sticky flag for a trap taken inside the handler
module trap_handler_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] STVEC_RESET  = 'h100,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            exception_flag_i,
    input  logic [31:0]     scause_i,
    input  logic [XLEN-1:0] sepc_i,
    input  logic            sret_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            flush_o,
    output logic            stall_if_o,
    output logic            pc_redirect_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            in_trap_o,
    output logic            double_fault_o
);
    typedef enum logic [2:0] {ST_IDLE, ST_FLUSH, ST_REDIRECT, ST_HANDLER, ST_RETURN} state_t;

    localparam logic [XLEN-1:0] STVEC_INIT = {STVEC_RESET[XLEN-1:2], 2'b00};
    localparam logic [3:0]      CNT_INIT   = 4'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] stvec_q, stvec_d, sepc_q, sepc_d, target_d;
    logic [31:0]     scause_q, scause_d;
    logic            take, df_d;
    logic            flush_d, stall_d, redir_d, in_trap_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE:     take = exception_flag_i;
            ST_FLUSH:    begin
                state_d = (cnt_q == 4'd0) ? ST_REDIRECT : ST_FLUSH;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            ST_REDIRECT: state_d = ST_HANDLER;
            ST_HANDLER:  begin
                take    = exception_flag_i;
                state_d = sret_i ? ST_RETURN : ST_HANDLER;
            end
            ST_RETURN:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // a trap request overrides any other transition, including a simultaneous SRET
        if (take) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_INIT;
        end
    end

    // trap capture has priority over software writes to sepc/scause
    assign stvec_d  = (csr_we_i && csr_addr_i == 12'h105) ? {csr_wdata_i[XLEN-1:2], 2'b00} : stvec_q;
    assign sepc_d   = take ? sepc_i : (csr_we_i && csr_addr_i == 12'h141) ? csr_wdata_i : sepc_q;
    assign scause_d = take ? scause_i : (csr_we_i && csr_addr_i == 12'h142) ? csr_wdata_i[31:0] : scause_q;
    assign df_d     = double_fault_o | (state_q == ST_HANDLER && exception_flag_i);

    // outputs are registered by decoding the next state, so stvec/sepc writes landing on the
    // entry edge are reflected in the redirect target
    assign flush_d   = state_d inside {ST_FLUSH, ST_REDIRECT, ST_RETURN};
    assign stall_d   = state_d == ST_FLUSH;
    assign redir_d   = state_d inside {ST_REDIRECT, ST_RETURN};
    assign in_trap_d = state_d inside {ST_HANDLER, ST_RETURN};
    assign target_d  = (state_d == ST_REDIRECT) ? stvec_d : (state_d == ST_RETURN) ? sepc_d : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            stvec_q        <= STVEC_INIT;
            sepc_q         <= '0;
            scause_q       <= '0;
            flush_o        <= 1'b0;
            stall_if_o     <= 1'b0;
            pc_redirect_o  <= 1'b0;
            pc_target_o    <= '0;
            in_trap_o      <= 1'b0;
            double_fault_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stvec_q        <= stvec_d;
            sepc_q         <= sepc_d;
            scause_q       <= scause_d;
            flush_o        <= flush_d;
            stall_if_o     <= stall_d;
            pc_redirect_o  <= redir_d;
            pc_target_o    <= target_d;
            in_trap_o      <= in_trap_d;
            double_fault_o <= df_d;
        end
    end

    assign csr_rdata_o = (csr_addr_i == 12'h105) ? stvec_q :
                         (csr_addr_i == 12'h141) ? sepc_q :
                         (csr_addr_i == 12'h142) ? {{(XLEN-32){1'b0}}, scause_q} : '0;
endmodule

// File: tb/tb_trap_handler_unit.sv
// tb_trap_handler_unit: directed scoreboard bench for trap_handler_unit
module tb_trap_handler_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flag = 1'b0;
    logic [31:0] scause = '0;
    logic [63:0] sepc = '0;
    logic        sret = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [63:0] rdata, target;
    logic        flush, stall, redir, in_trap, dfault;

    typedef struct {
        logic [63:0] tgt;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    trap_handler_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .exception_flag_i(flag), .scause_i(scause), .sepc_i(sepc),
        .sret_i(sret), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata), .csr_rdata_o(rdata),
        .flush_o(flush), .stall_if_o(stall), .pc_redirect_o(redir), .pc_target_o(target),
        .in_trap_o(in_trap), .double_fault_o(dfault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: every redirect strobe must match the oldest expected redirect
    always @(negedge clk) begin
        if (redir) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_redirect: got target %h at cycle %0d, required no redirect", target, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (target !== e.tgt || cyc != e.cyc || flush !== 1'b1 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect: got target %h cyc %0d flush %b stall %b, required target %h cyc %0d flush 1 stall 0",
                             target, cyc, flush, stall, e.tgt, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, input string name, input logic [63:0] exp);
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] t, input int c);
        exp_t e;
        e.tgt = t;
        e.cyc = c;
        q.push_back(e);
    endtask

    initial begin
        // 1: reset state
        repeat (2) step();
        chk("rst_ctrl", {flush, stall, redir, in_trap, dfault}, '0);
        chk("rst_target", target, '0);
        rd(12'h105, "rst_stvec", 64'h100);
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_ctrl", {flush, stall, in_trap}, '0);
        // 2: first trap, redirect three cycles after the flag is driven
        flag = 1'b1; scause = 32'd2; sepc = 64'h40;
        push(64'h100, cyc + 3);
        step(); flag = 1'b0;
        chk("flush1", {flush, stall}, 2'b11);
        step();
        chk("flush2", {flush, stall}, 2'b11);
        step();
        step();
        chk("handler_ctrl", {in_trap, redir, flush, stall}, 4'b1000);
        rd(12'h141, "sepc_cap", 64'h40);
        rd(12'h142, "scause_cap", 64'h2);
        rd(12'h7ff, "unknown_csr", 64'h0);
        // 3: software adjusts sepc, then SRET returns to it
        we = 1'b1; addr = 12'h141; wdata = 64'h44;
        step(); we = 1'b0;
        sret = 1'b1;
        push(64'h44, cyc + 1);
        step(); sret = 1'b0;
        chk("return_ctrl", {in_trap, flush}, 2'b11);
        step();
        chk("idle_after_ret", {in_trap, redir, flush}, 3'b000);
        // 4: stvec written during FLUSH is honoured, flag during FLUSH is ignored
        flag = 1'b1; scause = 32'd7; sepc = 64'h90;
        push(64'h200, cyc + 3);
        step();
        we = 1'b1; addr = 12'h105; wdata = 64'h203;
        scause = 32'd9; sepc = 64'h99;
        step(); we = 1'b0; flag = 1'b0;
        step();
        step();
        rd(12'h142, "scause_keep", 64'h7);
        rd(12'h141, "sepc_keep", 64'h90);
        rd(12'h105, "stvec_align", 64'h200);
        chk("no_df", {28'd0, dfault}, '0);
        // 5: trap and SRET together in HANDLER -> re-trap wins
        flag = 1'b1; scause = 32'd5; sepc = 64'h80; sret = 1'b1;
        push(64'h200, cyc + 3);
        step(); flag = 1'b0; sret = 1'b0;
        chk("double_fault", {28'd0, dfault}, 1);
        chk("retrap_flush", {flush, stall, redir}, 3'b110);
        step();
        step();
        step();
        rd(12'h141, "sepc_retrap", 64'h80);
        rd(12'h142, "scause_retrap", 64'h5);
        sret = 1'b1;
        push(64'h80, cyc + 1);
        step(); sret = 1'b0;
        step();
        // 6: reset mid-FLUSH, then SRET while IDLE does nothing
        flag = 1'b1; scause = 32'd3; sepc = 64'h10;
        step(); flag = 1'b0;
        chk("flush_before_rst", {flush, stall}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", {flush, stall, redir, in_trap, dfault}, '0);
        rd(12'h105, "rst_stvec2", 64'h100);
        rd(12'h141, "rst_sepc", 64'h0);
        rd(12'h142, "rst_scause", 64'h0);
        step(); rst_n = 1'b1;
        step();
        sret = 1'b1;
        step(); sret = 1'b0;
        chk("idle_sret_ignored", {redir, flush, in_trap}, 3'b000);
        repeat (3) step();
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_redirects: got %0d outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
